match_sequencer: RTL and testbench
==================================

# match_sequencer

Packet-level controller for a bank of `streaming` string matchers in the Ethernet sniffer. It programs each matcher's flagged string and length, and forwards 32-bit packet words into the shared matcher data bus. At end of packet it waits out the matcher pipeline, collects a per-matcher sticky match vector, and pulses the matchers' `clear`. It then reports a per-packet result through a valid/ready handshake.

## Interface
- `NUM_MATCHERS`, 4: matchers in the bank (1..8).
- `DRAIN_CYCLES`, 6: matcher latency, data_in to data_out/match.
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `cfg_wr` in 1: configuration write request.
- `cfg_ready` out 1: configuration accepted this cycle (high only in IDLE).
- `cfg_sel` in 3: target matcher slot.
- `cfg_string` in 136: flagged string, `[0:16][7:0]`, byte 0 first.
- `cfg_strlen` in 5: string length in bytes; 0 disables the slot.
- `pkt_valid` in 1: packet word valid.
- `pkt_ready` out 1: word consumed when `pkt_valid && pkt_ready`.
- `pkt_sop` in 1: first word of packet.
- `pkt_eop` in 1: last word of packet.
- `pkt_data` in 32: packet word.
- `m_data_in` out 32: registered data to all matchers.
- `m_clear` out 1: one-cycle clear to all matchers.
- `m_flagged_string` out NUM_MATCHERS*136: per-slot string, slot 0 in LSBs.
- `m_strlen` out NUM_MATCHERS*5: per-slot length.
- `m_match` in NUM_MATCHERS: matcher match flags.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed when both are high.
- `res_match` out NUM_MATCHERS: sticky match vector for the packet.
- `res_words` out 16: packet word count, saturating at 16'hFFFF.

## Operation
- FSM has five states: IDLE, STREAM, DRAIN, CLEAR, REPORT.
- Reset values:
  - state is IDLE.
  - `m_data_in`, `m_clear`, `res_valid`, `res_match` and `res_words` are 0.
  - All slot strings and lengths are 0.
  - `cfg_ready` and `pkt_ready` are 1, because the state is IDLE.
- IDLE:
  - `pkt_ready`=1 and `cfg_ready`=1.
  - A write with `cfg_wr` stores `cfg_string`/`cfg_strlen` into slot `cfg_sel`. Writes with `cfg_sel >= NUM_MATCHERS` are dropped. Lengths above 17 are clamped to 17.
  - An accepted word with `pkt_sop` loads `m_data_in`, sets the word count to 1 and clears the sticky vector. The FSM goes to STREAM, or to DRAIN if `pkt_eop` is also set.
  - An accepted word without `pkt_sop` is discarded. `m_data_in`=0.
- STREAM:
  - `pkt_ready`=1 and `cfg_ready`=0.
  - Each accepted word goes to `m_data_in` and increments the count.
  - A cycle with no accepted word drives `m_data_in`=0.
  - `pkt_sop` is ignored here, and the word is treated as data.
  - An accepted `pkt_eop` moves the FSM to DRAIN.
- DRAIN:
  - `pkt_ready`=0 and `m_data_in`=0.
  - Lasts exactly DRAIN_CYCLES+1 cycles, then moves to CLEAR.
- Sticky vector: in STREAM and DRAIN, `res_match[k] |= m_match[k]` every cycle for enabled slots (strlen != 0). Disabled slots always report 0.
- CLEAR: `m_clear`=1 for one cycle, then REPORT.
- REPORT:
  - `res_valid`=1, with `res_match`/`res_words` held stable.
  - On `res_ready` the FSM returns to IDLE and `res_valid` drops on the next edge.
  - `pkt_ready`=0 throughout.
- Reset mid-operation aborts immediately to reset values. Slot configuration is lost.

## Timing
- `m_data_in` shows a word 1 cycle after it is accepted.
- From the edge accepting `pkt_eop` to `res_valid` high is DRAIN_CYCLES+2 edges (8 at default).
- `m_clear` is high during the cycle before `res_valid` rises.
- A configuration write takes effect on `m_flagged_string`/`m_strlen` the next cycle.
- Minimum gap between packets: a new sop is accepted no earlier than the cycle after the `res_valid && res_ready` handshake.
- `res_valid`, `res_match` and `res_words` may not change while `res_valid && !res_ready`.

## Structure
- `sniffer_pkg` holds:
  - `MAX_STR_BYTES`=17
  - `flag_str_t` (`logic [0:16][7:0]`)
  - `strlen_t` (`logic [4:0]`)
  - the `seq_state_t` enum
- Single module. The slot configuration register file is a natural sub-module, `match_cfg_regs`.
- The `streaming` instances live in the parent, not here.

## Test plan
- **Reset:** assert `n_rst`=0 mid-STREAM -> outputs at reset values, `pkt_ready`=1, `m_strlen` all 0.
- **Single hit:**
  - Setup: slot 0 = "www.purdue.edu", strlen 14. Stream 20 words (sop on word 1, eop on word 20) and force `m_match[0]` high for 1 cycle during DRAIN.
  - Required: `m_clear` pulses once; `res_valid` appears 8 edges after eop; `res_match`=4'b0001, `res_words`=20.
- **Disabled slot:** slot 2 strlen 0, `m_match[2]` held high -> `res_match[2]`=0.
- **Backpressure:**
  - Setup: hold `res_ready`=0 for 5 cycles; present cfg writes and a new sop meanwhile.
  - Required: result stable, `pkt_ready`=0 and `cfg_ready`=0; the write is taken only after return to IDLE.
- **Edge packets:**
  - Sop+eop on the same word -> `res_words`=1.
  - Word without sop in IDLE -> dropped, `m_data_in` stays 0.
  - Gaps with `pkt_valid`=0 in STREAM -> `m_data_in`=0 on those cycles, count unchanged.
- **Config edges:** `cfg_strlen`=25 -> `m_strlen` slot reads 17; `cfg_sel`=5 with NUM_MATCHERS=4 -> no slot changes.

Source files
------------

// File: rtl/sniffer_pkg.sv
// Shared types for the Ethernet sniffer match path.
//   MAX_STR_BYTES : longest flagged string a matcher can hold
//   flag_str_t    : flagged string, byte 0 first (MSB end)
//   strlen_t      : string length in bytes, 0 = slot disabled
//   seq_state_t   : match_sequencer FSM states
//   clamp_len()   : limits a requested length to MAX_STR_BYTES
package sniffer_pkg;
  localparam int MAX_STR_BYTES = 17;

  typedef logic [0:16][7:0] flag_str_t;
  typedef logic [4:0]       strlen_t;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_STREAM = 3'd1,
    SEQ_DRAIN  = 3'd2,
    SEQ_CLEAR  = 3'd3,
    SEQ_REPORT = 3'd4
  } seq_state_t;

  function automatic strlen_t clamp_len(input strlen_t len);
    return (len > strlen_t'(MAX_STR_BYTES)) ? strlen_t'(MAX_STR_BYTES) : len;
  endfunction
endpackage

// File: rtl/match_sequencer_if.sv
// Handshake bundle between a packet source and match_sequencer.
//   cfg_* : slot configuration write (cfg_wr / cfg_ready)
//   pkt_* : packet word stream (pkt_valid / pkt_ready, sop/eop framing)
//   res_* : per-packet result (res_valid / res_ready)
// master = packet source side, slave = match_sequencer side.
interface match_sequencer_if #(
  parameter int NUM_MATCHERS = 4
);
  import sniffer_pkg::*;

  logic                    cfg_wr;
  logic                    cfg_ready;
  logic [2:0]              cfg_sel;
  flag_str_t               cfg_string;
  strlen_t                 cfg_strlen;

  logic                    pkt_valid;
  logic                    pkt_ready;
  logic                    pkt_sop;
  logic                    pkt_eop;
  logic [31:0]             pkt_data;

  logic                    res_valid;
  logic                    res_ready;
  logic [NUM_MATCHERS-1:0] res_match;
  logic [15:0]             res_words;

  modport master (
    output cfg_wr, cfg_sel, cfg_string, cfg_strlen,
    output pkt_valid, pkt_sop, pkt_eop, pkt_data,
    output res_ready,
    input  cfg_ready, pkt_ready, res_valid, res_match, res_words
  );

  modport slave (
    input  cfg_wr, cfg_sel, cfg_string, cfg_strlen,
    input  pkt_valid, pkt_sop, pkt_eop, pkt_data,
    input  res_ready,
    output cfg_ready, pkt_ready, res_valid, res_match, res_words
  );
endinterface

// File: rtl/match_sequencer_cfg_regs.sv
// match_cfg_regs: per-slot flagged string / length register file.
//   clk, n_rst : clock, async active-low reset (all slots cleared)
//   i_we       : write strobe (already qualified by the caller)
//   i_sel      : target slot; values >= NUM_MATCHERS match no slot
//   i_string   : string to store
//   i_len      : length to store, clamped to MAX_STR_BYTES
//   o_strings  : all slot strings, slot 0 in LSBs
//   o_lens     : all slot lengths, slot 0 in LSBs
//   o_en       : per-slot enable (length != 0)
module match_cfg_regs
  import sniffer_pkg::*;
#(
  parameter int NUM_MATCHERS = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_we,
  input  logic [2:0]                  i_sel,
  input  flag_str_t                   i_string,
  input  strlen_t                     i_len,
  output logic [NUM_MATCHERS*136-1:0] o_strings,
  output logic [NUM_MATCHERS*5-1:0]   o_lens,
  output logic [NUM_MATCHERS-1:0]     o_en
);
  logic [NUM_MATCHERS-1:0][135:0] r_str;
  logic [NUM_MATCHERS-1:0][4:0]   r_len;

  for (genvar k = 0; k < NUM_MATCHERS; k++) begin : g_slot
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_str[k] <= '0;
        r_len[k] <= '0;
      end else if (i_we && i_sel == 3'(k)) begin
        r_str[k] <= i_string;
        r_len[k] <= clamp_len(i_len);
      end
    end
    assign o_en[k] = |r_len[k];
  end

  assign o_strings = r_str;
  assign o_lens    = r_len;
endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: packet-level controller for a bank of streaming matchers.
// Programs matcher slots, forwards packet words onto the shared matcher data
// bus, waits out the matcher pipeline after eop, pulses clear, and reports a
// sticky per-slot match vector plus word count.
//   clk, n_rst       : clock, async active-low reset
//   bus              : cfg / pkt / res handshakes (slave side)
//   m_data_in        : registered packet word to all matchers (0 when idle)
//   m_clear          : one-cycle clear to all matchers
//   m_flagged_string : per-slot strings, slot 0 in LSBs
//   m_strlen         : per-slot lengths, slot 0 in LSBs
//   m_match          : per-matcher match flags
module match_sequencer
  import sniffer_pkg::*;
#(
  parameter int NUM_MATCHERS = 4,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                        clk,
  input  logic                        n_rst,
  match_sequencer_if.slave            bus,
  output logic [31:0]                 m_data_in,
  output logic                        m_clear,
  output logic [NUM_MATCHERS*136-1:0] m_flagged_string,
  output logic [NUM_MATCHERS*5-1:0]   m_strlen,
  input  logic [NUM_MATCHERS-1:0]     m_match
);
  localparam logic [2:0] S_IDLE   = 3'(SEQ_IDLE);
  localparam logic [2:0] S_STREAM = 3'(SEQ_STREAM);
  localparam logic [2:0] S_DRAIN  = 3'(SEQ_DRAIN);
  localparam logic [2:0] S_CLEAR  = 3'(SEQ_CLEAR);
  localparam logic [2:0] S_REPORT = 3'(SEQ_REPORT);
  // Drain counter runs 0..DRAIN_CYCLES, i.e. DRAIN_CYCLES+1 cycles.
  localparam int CW = $clog2(DRAIN_CYCLES + 2);

  logic [2:0]              r_state;
  logic [31:0]             r_data;
  logic [15:0]             r_words;
  logic [NUM_MATCHERS-1:0] r_match;
  logic [CW-1:0]           r_cnt;

  logic                    w_idle;
  logic                    w_acc;
  logic [NUM_MATCHERS-1:0] w_en;
  logic [NUM_MATCHERS-1:0] w_hit;

  assign w_idle = (r_state == S_IDLE);
  assign bus.pkt_ready = w_idle || (r_state == S_STREAM);
  assign bus.cfg_ready = w_idle;
  assign w_acc  = bus.pkt_valid && bus.pkt_ready;
  assign w_hit  = m_match & w_en;

  match_cfg_regs #(.NUM_MATCHERS(NUM_MATCHERS)) u_cfg (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_we      (bus.cfg_wr && w_idle),
    .i_sel     (bus.cfg_sel),
    .i_string  (bus.cfg_string),
    .i_len     (bus.cfg_strlen),
    .o_strings (m_flagged_string),
    .o_lens    (m_strlen),
    .o_en      (w_en)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_words <= '0;
      r_match <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_data <= '0;
          r_cnt  <= '0;
          // Words without sop are dropped here; only sop opens a packet.
          if (w_acc && bus.pkt_sop) begin
            r_data  <= bus.pkt_data;
            r_words <= 16'd1;
            r_match <= '0;
            r_state <= bus.pkt_eop ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          r_match <= r_match | w_hit;
          r_data  <= w_acc ? bus.pkt_data : '0;
          if (w_acc) begin
            if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
            if (bus.pkt_eop) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_data  <= '0;
          r_match <= r_match | w_hit;
          if (r_cnt == CW'(DRAIN_CYCLES)) r_state <= S_CLEAR;
          else                            r_cnt   <= r_cnt + CW'(1);
        end
        S_CLEAR:  r_state <= S_REPORT;
        S_REPORT: if (bus.res_ready) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign m_data_in     = r_data;
  assign m_clear       = (r_state == S_CLEAR);
  assign bus.res_valid = (r_state == S_REPORT);
  // Disabled slots never report a hit.
  assign bus.res_match = r_match & w_en;
  assign bus.res_words = r_words;
endmodule

// File: tb/tb_match_sequencer.sv
module tb_match_sequencer;
  import sniffer_pkg::*;

  localparam int NM = 4;
  localparam int DC = 6;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic [31:0]       m_data_in;
  logic              m_clear;
  logic [NM*136-1:0] m_flagged_string;
  logic [NM*5-1:0]   m_strlen;
  logic [NM-1:0]     m_match;

  match_sequencer_if #(.NUM_MATCHERS(NM)) bus ();

  match_sequencer #(.NUM_MATCHERS(NM), .DRAIN_CYCLES(DC)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .bus              (bus),
    .m_data_in        (m_data_in),
    .m_clear          (m_clear),
    .m_flagged_string (m_flagged_string),
    .m_strlen         (m_strlen),
    .m_match          (m_match)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference slot configuration.
  logic [135:0] mdl_str [NM];
  int           mdl_len [NM];

  typedef struct {
    logic [2:0]   sel;
    logic [4:0]   len;
    logic [135:0] str;
    logic [19:0]  exp_lens;
  } cfg_vec_t;
  cfg_vec_t tbl [7];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.cfg_wr = 0; bus.cfg_sel = '0; bus.cfg_string = '0; bus.cfg_strlen = '0;
    bus.pkt_valid = 0; bus.pkt_sop = 0; bus.pkt_eop = 0; bus.pkt_data = '0;
    bus.res_ready = 0; m_match = '0;
  endtask

  function automatic logic [NM*5-1:0] mdl_lens();
    logic [NM*5-1:0] r;
    for (int k = 0; k < NM; k++) r[k*5 +: 5] = 5'(mdl_len[k]);
    return r;
  endfunction

  function automatic logic [NM-1:0] rnd_inj(input int pct);
    logic [NM-1:0] r;
    for (int b = 0; b < NM; b++) r[b] = (int'($urandom_range(99)) < pct);
    return r;
  endfunction

  task automatic cfg_write(input logic [2:0] sel, input logic [135:0] s, input logic [4:0] len);
    bus.cfg_wr = 1; bus.cfg_sel = sel; bus.cfg_string = s; bus.cfg_strlen = len;
    chk("cfg_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_wr = 0;
    if (sel < NM) begin
      mdl_str[sel] = s;
      mdl_len[sel] = (len > 17) ? 17 : int'(len);
    end
    chk("cfg_lens", m_strlen, mdl_lens());
    for (int k = 0; k < NM; k++) chk("cfg_str", m_flagged_string[k*136 +: 136], mdl_str[k]);
  endtask

  // One full packet: stream n words (random gaps), drain, report, handshake.
  // Expected hit vector = OR of m_match over the STREAM+DRAIN window, masked
  // by enabled slots; expected count = n.
  task automatic run_pkt(input int n, input int gap_pct, input int inj_pct,
                         input logic [NM-1:0] hold, input logic [NM-1:0] pulse,
                         input int rdy_dly,
                         output logic [NM-1:0] got_m, output logic [15:0] got_w);
    logic [NM-1:0] acc, mm, en, exp_m;
    logic [31:0]   w;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0)
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
          bus.pkt_valid = 0; bus.pkt_sop = 1'($urandom_range(1)); bus.pkt_data = $urandom;
          mm = rnd_inj(inj_pct) | hold; m_match = mm; acc |= mm;
          tick();
          chk("gap_data", m_data_in, 0);
        end
      w = $urandom;
      bus.pkt_valid = 1; bus.pkt_data = w; bus.pkt_eop = (i == n-1);
      bus.pkt_sop = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      if (i == 0) m_match = NM'($urandom);   // sop edge clears the sticky vector
      else begin mm = rnd_inj(inj_pct) | hold; m_match = mm; acc |= mm; end
      chk("pkt_ready", bus.pkt_ready, 1);
      tick();
      chk("word_data", m_data_in, w);
    end
    for (int k = 1; k <= DC+2; k++) begin
      bus.pkt_valid = 1'($urandom_range(1)); bus.pkt_sop = 1'($urandom_range(1)); bus.pkt_eop = 0;
      if (k <= DC+1) begin
        mm = rnd_inj(inj_pct) | hold | ((k == 3) ? pulse : '0);
        acc |= mm;
      end else mm = NM'($urandom);
      m_match = mm;
      tick();
      chk("drain_data", m_data_in, 0);
      chk("drain_pkt_ready", bus.pkt_ready, 0);
      chk("m_clear", m_clear, (k == DC+1));
      chk("res_valid_rise", bus.res_valid, (k == DC+2));
    end
    for (int b = 0; b < NM; b++) en[b] = (mdl_len[b] != 0);
    exp_m = acc & en;
    chk("res_match", bus.res_match, exp_m);
    chk("res_words", bus.res_words, 16'(n));
    got_m = bus.res_match;
    got_w = bus.res_words;
    for (int j = 0; j < rdy_dly; j++) begin
      bus.res_ready = 0; bus.cfg_wr = 1; bus.cfg_sel = 3'($urandom_range(7));
      bus.cfg_strlen = 5'($urandom_range(31));
      bus.cfg_string = 136'({$urandom, $urandom, $urandom, $urandom, $urandom});
      bus.pkt_valid = 1; bus.pkt_sop = 1; bus.pkt_eop = 1'($urandom_range(1));
      m_match = NM'($urandom);
      tick();
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_match", bus.res_match, exp_m);
      chk("bp_res_words", bus.res_words, 16'(n));
      chk("bp_pkt_ready", bus.pkt_ready, 0);
      chk("bp_cfg_ready", bus.cfg_ready, 0);
      chk("bp_strlen", m_strlen, mdl_lens());
    end
    idle_in();
    bus.res_ready = 1;
    tick();
    bus.res_ready = 0;
    chk("hs_res_valid", bus.res_valid, 0);
    chk("hs_cfg_ready", bus.cfg_ready, 1);
    chk("hs_strlen", m_strlen, mdl_lens());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NM-1:0] gm;
    logic [15:0]   gw;

    tbl[0] = '{3'd0, 5'd14, {"www.purdue.edu", 24'h0}, 20'h0000E};
    tbl[1] = '{3'd1, 5'd25, {17{8'hA5}},               20'h0022E};
    tbl[2] = '{3'd5, 5'd3,  {17{8'h3C}},               20'h0022E};
    tbl[3] = '{3'd3, 5'd31, {17{8'h71}},               20'h8822E};
    tbl[4] = '{3'd2, 5'd0,  {17{8'hEE}},               20'h8822E};
    tbl[5] = '{3'd1, 5'd5,  {17{8'h12}},               20'h880AE};
    tbl[6] = '{3'd7, 5'd9,  {17{8'h99}},               20'h880AE};

    for (int k = 0; k < NM; k++) begin mdl_str[k] = '0; mdl_len[k] = 0; end
    idle_in();
    #2 n_rst = 0;
    #20;
    chk("rst_data", m_data_in, 0);
    chk("rst_clear", m_clear, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_match", bus.res_match, 0);
    chk("rst_res_words", bus.res_words, 0);
    chk("rst_pkt_ready", bus.pkt_ready, 1);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_strlen", m_strlen, 0);
    @(negedge clk) n_rst = 1;
    tick();

    // Config table: clamp, out-of-range select, disable, overwrite.
    for (int i = 0; i < 7; i++) begin
      cfg_write(tbl[i].sel, tbl[i].str, tbl[i].len);
      chk("cfg_tbl_lens", m_strlen, tbl[i].exp_lens);
    end

    // Single hit on slot 0 during drain; slot 2 (disabled) held high.
    run_pkt(20, 0, 0, 4'b0100, 4'b0001, 0, gm, gw);
    chk("hit_res_match", gm, 4'b0001);
    chk("hit_res_words", gw, 16'd20);

    // Backpressure with cfg writes and sop presented during REPORT.
    run_pkt(3, 30, 20, '0, '0, 5, gm, gw);
    cfg_write(3'd1, {17{8'h44}}, 5'd9);
    chk("bp_cfg_after", m_strlen[9:5], 5'd9);

    // sop+eop on the same word.
    run_pkt(1, 0, 30, '0, '0, 1, gm, gw);
    chk("single_word", gw, 16'd1);

    // Word without sop in IDLE is dropped.
    bus.pkt_valid = 1; bus.pkt_sop = 0; bus.pkt_eop = 1; bus.pkt_data = 32'hDEADBEEF;
    tick();
    bus.pkt_valid = 0; bus.pkt_eop = 0;
    chk("nosop_data", m_data_in, 0);
    chk("nosop_cfg_ready", bus.cfg_ready, 1);
    tick();
    chk("nosop_res_valid", bus.res_valid, 0);
    chk("nosop_data2", m_data_in, 0);

    // Heavy gaps in STREAM.
    run_pkt(5, 90, 30, '0, '0, 1, gm, gw);
    chk("gap_words", gw, 16'd5);

    // Random configuration and packets.
    for (int r = 0; r < 25; r++) begin
      cfg_write(3'($urandom_range(7)),
                136'({$urandom, $urandom, $urandom, $urandom, $urandom}),
                5'($urandom_range(31)));
      run_pkt(int'($urandom_range(12, 1)), int'($urandom_range(60)), int'($urandom_range(30)),
              '0, '0, int'($urandom_range(3)), gm, gw);
    end

    // Reset in the middle of a packet.
    cfg_write(3'd0, {17{8'h5A}}, 5'd12);
    bus.pkt_valid = 1; bus.pkt_sop = 1; bus.pkt_eop = 0; bus.pkt_data = $urandom;
    tick();
    bus.pkt_sop = 0;
    tick();
    chk("mid_cfg_ready", bus.cfg_ready, 0);
    #2 n_rst = 0;
    #1;
    for (int k = 0; k < NM; k++) begin mdl_str[k] = '0; mdl_len[k] = 0; end
    chk("mrst_data", m_data_in, 0);
    chk("mrst_clear", m_clear, 0);
    chk("mrst_res_valid", bus.res_valid, 0);
    chk("mrst_res_match", bus.res_match, 0);
    chk("mrst_res_words", bus.res_words, 0);
    chk("mrst_pkt_ready", bus.pkt_ready, 1);
    chk("mrst_cfg_ready", bus.cfg_ready, 1);
    chk("mrst_strlen", m_strlen, mdl_lens());
    chk("mrst_str0", m_flagged_string[135:0], 0);
    idle_in();
    @(negedge clk) n_rst = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
